// File: rtl/muldiv_pkg.sv
// ============================================================================
// muldiv_pkg : shared op encodings, state enum and constants for muldiv_sequencer
// Optional feature macro: MULDIV_SIGNED_EN (adds OP_MULTS / OP_DIVS)
// Revision: 1.0
// ============================================================================
`default_nettype none

package muldiv_pkg;

`ifdef MULDIV_SIGNED_EN
  localparam int OP_W = 3;
`else
  localparam int OP_W = 2;
`endif

  localparam logic [OP_W-1:0] OP_MULT  = OP_W'(0);
  localparam logic [OP_W-1:0] OP_DIV   = OP_W'(1);
  localparam logic [OP_W-1:0] OP_MTHI  = OP_W'(2);
  localparam logic [OP_W-1:0] OP_MTLO  = OP_W'(3);
`ifdef MULDIV_SIGNED_EN
  localparam logic [OP_W-1:0] OP_MULTS = OP_W'(4);
  localparam logic [OP_W-1:0] OP_DIVS  = OP_W'(5);
`endif

  // LO value for a divide by zero; sliced down to the datapath width
  localparam logic [63:0] DIV_ZERO_LO = '1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

endpackage

`default_nettype wire

// File: rtl/muldiv_step.sv
// ============================================================================
// muldiv_step : one combinational iteration, shift-add multiply (mode 0) or
//               restoring-divide step (mode 1) on a {hi,lo} accumulator pair
// Revision: 1.0
// ============================================================================
`default_nettype none

module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic             mode_in,
  input  logic [WIDTH-1:0] hi_in,
  input  logic [WIDTH-1:0] lo_in,
  input  logic [WIDTH-1:0] b_in,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;
  logic             borrow;

  always_comb begin
    sum     = lo_in[0] ? ({1'b0, hi_in} + {1'b0, b_in}) : {1'b0, hi_in};
    shifted = {hi_in, lo_in[WIDTH-1]};
    borrow  = shifted < {1'b0, b_in};
    // a non-borrowing difference is below b, so the low WIDTH bits are exact
    diff    = shifted[WIDTH-1:0] - b_in;
    if (mode_in) begin
      hi_out = borrow ? shifted[WIDTH-1:0] : diff;
      lo_out = {lo_in[WIDTH-2:0], ~borrow};
    end else begin
      hi_out = sum[WIDTH:1];
      lo_out = {sum[0], lo_in[WIDTH-1:1]};
    end
  end

endmodule

`default_nettype wire

// File: rtl/muldiv_sequencer.sv
// ============================================================================
// muldiv_sequencer : multi-cycle MULT/DIV unit owning architectural HI/LO
// Optional feature macro: MULDIV_SIGNED_EN (signed MULTS/DIVS)
// Revision: 1.0
// ============================================================================
`default_nettype none

module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             start_in,
  input  logic [OP_W-1:0]  op_in,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             flush_in,
  output logic             busy_out,
  output logic             done_out,
  output logic             div_zero_out,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             div_zero_q, div_zero_d;
  logic [WIDTH-1:0] step_hi, step_lo;
  logic             accept;
  logic             last_step;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0] quot, rem;
`ifdef MULDIV_SIGNED_EN
  logic             neg_q_q, neg_q_d;
  logic             neg_r_q, neg_r_d;
  logic [WIDTH-1:0] a_mag, b_mag;
`endif

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .mode_in (state_q == ST_DIV),
    .hi_in   (acc_hi_q),
    .lo_in   (acc_lo_q),
    .b_in    (opb_q),
    .hi_out  (step_hi),
    .lo_out  (step_lo)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_hi_d   = acc_hi_q;
    acc_lo_d   = acc_lo_q;
    opb_d      = opb_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    div_zero_d = 1'b0;
    accept     = ((state_q == ST_IDLE) || (state_q == ST_DONE)) && start_in && !flush_in;
    last_step  = (cnt_q == CNT_W'(WIDTH - 1));
    prod       = {step_hi, step_lo};
    quot       = step_lo;
    rem        = step_hi;
`ifdef MULDIV_SIGNED_EN
    neg_q_d    = neg_q_q;
    neg_r_d    = neg_r_q;
    a_mag      = a_in[WIDTH-1] ? (~a_in + 1'b1) : a_in;
    b_mag      = b_in[WIDTH-1] ? (~b_in + 1'b1) : b_in;
    // sign fix-up happens only on the final step into DONE
    if (neg_q_q) begin
      prod = ~prod + 1'b1;
      quot = ~quot + 1'b1;
    end
    if (neg_r_q) rem = ~rem + 1'b1;
`endif

    case (state_q)
      ST_MUL, ST_DIV: begin
        if (flush_in) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          acc_hi_d = step_hi;
          acc_lo_d = step_lo;
          cnt_d    = cnt_q + CNT_W'(1);
          if (last_step) begin
            state_d = ST_DONE;
            cnt_d   = '0;
            if (state_q == ST_MUL) begin
              {hi_d, lo_d} = prod;
            end else begin
              hi_d = rem;
              lo_d = quot;
            end
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: ;
    endcase

    if (accept) begin
      case (op_in)
        OP_MULT: begin
          acc_hi_d = '0;
          acc_lo_d = a_in;
          opb_d    = b_in;
          cnt_d    = '0;
          state_d  = ST_MUL;
`ifdef MULDIV_SIGNED_EN
          neg_q_d  = 1'b0;
          neg_r_d  = 1'b0;
`endif
        end
        OP_DIV: begin
          if (b_in == '0) begin
            hi_d       = a_in;
            lo_d       = DIV_ZERO_LO[WIDTH-1:0];
            div_zero_d = 1'b1;
            state_d    = ST_DONE;
          end else begin
            acc_hi_d = '0;
            acc_lo_d = a_in;
            opb_d    = b_in;
            cnt_d    = '0;
            state_d  = ST_DIV;
`ifdef MULDIV_SIGNED_EN
            neg_q_d  = 1'b0;
            neg_r_d  = 1'b0;
`endif
          end
        end
        OP_MTHI: hi_d = a_in;
        OP_MTLO: lo_d = a_in;
`ifdef MULDIV_SIGNED_EN
        OP_MULTS: begin
          acc_hi_d = '0;
          acc_lo_d = a_mag;
          opb_d    = b_mag;
          cnt_d    = '0;
          state_d  = ST_MUL;
          neg_q_d  = a_in[WIDTH-1] ^ b_in[WIDTH-1];
          neg_r_d  = 1'b0;
        end
        OP_DIVS: begin
          if (b_in == '0) begin
            hi_d       = a_in;
            lo_d       = DIV_ZERO_LO[WIDTH-1:0];
            div_zero_d = 1'b1;
            state_d    = ST_DONE;
          end else begin
            acc_hi_d = '0;
            acc_lo_d = a_mag;
            opb_d    = b_mag;
            cnt_d    = '0;
            state_d  = ST_DIV;
            neg_q_d  = a_in[WIDTH-1] ^ b_in[WIDTH-1];
            neg_r_d  = a_in[WIDTH-1];
          end
        end
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      acc_hi_q   <= '0;
      acc_lo_q   <= '0;
      opb_q      <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      div_zero_q <= 1'b0;
`ifdef MULDIV_SIGNED_EN
      neg_q_q    <= 1'b0;
      neg_r_q    <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_hi_q   <= acc_hi_d;
      acc_lo_q   <= acc_lo_d;
      opb_q      <= opb_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      div_zero_q <= div_zero_d;
`ifdef MULDIV_SIGNED_EN
      neg_q_q    <= neg_q_d;
      neg_r_q    <= neg_r_d;
`endif
    end
  end

  assign busy_out     = (state_q == ST_MUL) || (state_q == ST_DIV);
  assign done_out     = (state_q == ST_DONE);
  assign div_zero_out = div_zero_q;
  assign hi_out       = hi_q;
  assign lo_out       = lo_q;

endmodule

`default_nettype wire

// File: tb/tb_muldiv_sequencer.sv
// ============================================================================
// tb_muldiv_sequencer : directed self-checking bench for muldiv_sequencer
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_muldiv_sequencer;

`ifdef MULDIV_SIGNED_EN
  localparam int TB_OP_W = 3;
`else
  localparam int TB_OP_W = 2;
`endif
  localparam logic [TB_OP_W-1:0] T_MULT = TB_OP_W'(0);
  localparam logic [TB_OP_W-1:0] T_DIV  = TB_OP_W'(1);
  localparam logic [TB_OP_W-1:0] T_MTHI = TB_OP_W'(2);
  localparam logic [TB_OP_W-1:0] T_MTLO = TB_OP_W'(3);

  logic               clk_in = 1'b0;
  logic               rst_n_in;
  logic               start_in;
  logic [TB_OP_W-1:0] op_in;
  logic [31:0]        a_in, b_in;
  logic               flush_in;
  logic               busy_out, done_out, div_zero_out;
  logic [31:0]        hi_out, lo_out;

  int checks   = 0;
  int failures = 0;

  muldiv_sequencer dut (
    .clk_in       (clk_in),
    .rst_n_in     (rst_n_in),
    .start_in     (start_in),
    .op_in        (op_in),
    .a_in         (a_in),
    .b_in         (b_in),
    .flush_in     (flush_in),
    .busy_out     (busy_out),
    .done_out     (done_out),
    .div_zero_out (div_zero_out),
    .hi_out       (hi_out),
    .lo_out       (lo_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one start for a single edge; returns 1 time unit after the accept edge
  task automatic issue(input logic [TB_OP_W-1:0] op, input logic [31:0] a, input logic [31:0] b);
    start_in = 1'b1;
    op_in    = op;
    a_in     = a;
    b_in     = b;
    @(posedge clk_in);
    #1;
    start_in = 1'b0;
  endtask

  // lat = edges after the accept edge until done_out is seen
  task automatic wait_done(output int lat, output int busy_n);
    lat    = 0;
    busy_n = 0;
    while (!done_out && lat < 100) begin
      if (busy_out) busy_n++;
      @(posedge clk_in);
      #1;
      lat++;
    end
  endtask

  int lat, busy_n, seen_done;

  initial begin
    rst_n_in = 1'b0;
    start_in = 1'b0;
    flush_in = 1'b0;
    op_in    = '0;
    a_in     = '0;
    b_in     = '0;
    #12;
    chk("rst_busy", 64'(busy_out), 64'd0);
    chk("rst_done", 64'(done_out), 64'd0);
    chk("rst_dz",   64'(div_zero_out), 64'd0);
    chk("rst_hi",   64'(hi_out), 64'd0);
    chk("rst_lo",   64'(lo_out), 64'd0);
    @(posedge clk_in);
    #1;
    rst_n_in = 1'b1;
    @(posedge clk_in);
    #1;

    // MULT 2^16 * 2^16 = 2^32
    issue(T_MULT, 32'h0001_0000, 32'h0001_0000);
    wait_done(lat, busy_n);
    chk("mult_lat",  64'(lat), 64'd32);
    chk("mult_busy", 64'(busy_n), 64'd32);
    chk("mult_hi",   64'(hi_out), 64'd1);
    chk("mult_lo",   64'(lo_out), 64'd0);
    @(posedge clk_in);
    #1;
    chk("done_one_cycle", 64'(done_out), 64'd0);

    // DIV 100 / 7
    issue(T_DIV, 32'd100, 32'd7);
    wait_done(lat, busy_n);
    chk("div_lat", 64'(lat), 64'd32);
    chk("div_lo",  64'(lo_out), 64'd14);
    chk("div_hi",  64'(hi_out), 64'd2);
    chk("div_dz",  64'(div_zero_out), 64'd0);
    @(posedge clk_in);
    #1;

    // DIV by zero: DONE straight from the accept edge
    issue(T_DIV, 32'd5, 32'd0);
    wait_done(lat, busy_n);
    chk("dz_lat", 64'(lat), 64'd0);
    chk("dz_hi",  64'(hi_out), 64'd5);
    chk("dz_lo",  64'(lo_out), 64'hFFFF_FFFF);
    chk("dz_flag", 64'(div_zero_out), 64'd1);
    @(posedge clk_in);
    #1;
    chk("dz_flag_clr", 64'(div_zero_out), 64'd0);

    // MTHI / MTLO
    issue(T_MTHI, 32'hDEAD_BEEF, 32'd0);
    chk("mthi_hi",   64'(hi_out), 64'hDEAD_BEEF);
    chk("mthi_done", 64'(done_out), 64'd0);
    chk("mthi_busy", 64'(busy_out), 64'd0);
    issue(T_MTLO, 32'h0000_1234, 32'd0);
    chk("mtlo_lo",   64'(lo_out), 64'h1234);
    chk("mtlo_hi",   64'(hi_out), 64'hDEAD_BEEF);
    chk("mtlo_done", 64'(done_out), 64'd0);

    // Starts while busy are ignored
    issue(T_MULT, 32'd3, 32'd5);
    lat = 0;
    while (!done_out && lat < 100) begin
      if (lat == 4 || lat == 9) begin
        start_in = 1'b1;
        op_in    = T_DIV;
        a_in     = 32'd77;
        b_in     = 32'd9;
      end
      @(posedge clk_in);
      #1;
      start_in = 1'b0;
      lat++;
    end
    chk("ign_lat", 64'(lat), 64'd32);
    chk("ign_hi",  64'(hi_out), 64'd0);
    chk("ign_lo",  64'(lo_out), 64'd15);
    @(posedge clk_in);
    #1;

    // Flush mid-MULT: HI/LO stay 0 / 15, no done
    issue(T_MULT, 32'hFFFF_FFFF, 32'd2);
    repeat (12) begin
      @(posedge clk_in);
      #1;
    end
    flush_in = 1'b1;
    @(posedge clk_in);
    #1;
    flush_in = 1'b0;
    chk("flush_busy", 64'(busy_out), 64'd0);
    seen_done = 0;
    for (int i = 0; i < 40; i++) begin
      if (done_out) seen_done++;
      @(posedge clk_in);
      #1;
    end
    chk("flush_nodone", 64'(seen_done), 64'd0);
    chk("flush_hi", 64'(hi_out), 64'd0);
    chk("flush_lo", 64'(lo_out), 64'd15);

    // Back-to-back start during DONE
    issue(T_DIV, 32'd100, 32'd7);
    wait_done(lat, busy_n);
    chk("b2b_first_lat", 64'(lat), 64'd32);
    issue(T_MULT, 32'd6, 32'd7);
    chk("b2b_busy", 64'(busy_out), 64'd1);
    chk("b2b_done", 64'(done_out), 64'd0);
    wait_done(lat, busy_n);
    chk("b2b_lat", 64'(lat), 64'd32);
    chk("b2b_hi",  64'(hi_out), 64'd0);
    chk("b2b_lo",  64'(lo_out), 64'd42);
    @(posedge clk_in);
    #1;

`ifdef MULDIV_SIGNED_EN
    issue(TB_OP_W'(4), 32'hFFFF_FFFD, 32'd5);
    wait_done(lat, busy_n);
    chk("mults_lat", 64'(lat), 64'd32);
    chk("mults_res", {hi_out, lo_out}, 64'hFFFF_FFFF_FFFF_FFF1);
    @(posedge clk_in);
    #1;
    issue(TB_OP_W'(5), 32'hFFFF_FFF9, 32'd2);
    wait_done(lat, busy_n);
    chk("divs_lo", 64'(lo_out), 64'hFFFF_FFFD);
    chk("divs_hi", 64'(hi_out), 64'hFFFF_FFFF);
    @(posedge clk_in);
    #1;
    issue(TB_OP_W'(5), 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(lat, busy_n);
    chk("divs_ovf_lo", 64'(lo_out), 64'h8000_0000);
    chk("divs_ovf_hi", 64'(hi_out), 64'd0);
    @(posedge clk_in);
    #1;
`endif

    // Asynchronous reset mid-DIV
    issue(T_DIV, 32'd1000, 32'd3);
    repeat (10) begin
      @(posedge clk_in);
      #1;
    end
    chk("pre_rst_busy", 64'(busy_out), 64'd1);
    rst_n_in = 1'b0;
    #1;
    chk("arst_busy", 64'(busy_out), 64'd0);
    chk("arst_hi",   64'(hi_out), 64'd0);
    chk("arst_lo",   64'(lo_out), 64'd0);
    @(posedge clk_in);
    #1;
    rst_n_in = 1'b1;
    repeat (40) begin
      @(posedge clk_in);
      #1;
    end
    chk("arst_idle_done", 64'(done_out), 64'd0);
    chk("arst_idle_lo",   64'(lo_out), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
